// File: rtl/int_prod_pkg.sv
// Shared types and helpers for the sequential inner-product unit.
// Holds the FSM state encoding, accumulator sizing and result saturation.
package int_prod_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int SAT_W = 64;

    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n) + 1;
    endfunction

    // Result packed as {value, ovf}; value is sign-extended to SAT_W bits.
    function automatic logic [SAT_W:0] sat_w(
        input logic signed [SAT_W-1:0] acc,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = ~hi;
        if (acc > hi) return {hi, 1'b1};
        if (acc < lo) return {lo, 1'b1};
        return {acc, 1'b0};
    endfunction

endpackage

// File: rtl/int_prod_lanes.sv
// Combinational chunk datapath: LANES signed W x W products summed
// into one sign-extended accumulator-width term.
module int_prod_lanes
    import int_prod_pkg::*;
#(
    parameter int W     = 8,
    parameter int LANES = 1,
    parameter int ACC_W = acc_width(LANES, W)
) (
    input  logic [LANES*W-1:0]       a,
    input  logic [LANES*W-1:0]       b,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [2*W-1:0] p;

    always_comb begin
        p   = '0;
        sum = '0;
        for (int j = 0; j < LANES; j++) begin
            p   = (2*W)'($signed(a[j*W +: W])) *
                  (2*W)'($signed(b[j*W +: W]));
            sum = sum + ACC_W'(p);
        end
    end

endmodule

// File: rtl/int_prod_seq.sv
// Sequential signed dot product of an N-element row and column,
// LANES pairs per clock, saturated to W bits with overflow flag.
module int_prod_seq
    import int_prod_pkg::*;
#(
    parameter int N     = 5,
    parameter int W     = 8,
    parameter int LANES = 1,
    parameter int ACC_W = acc_width(N, W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] lin,
    input  logic [N*W-1:0] col,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   n_out,
    output logic           ovf
);

    localparam int K  = N / LANES;
    localparam int CW = $clog2(K + 1);
    localparam logic [CW-1:0] KC = CW'(K);

    if (LANES < 1 || LANES > N || (N % LANES) != 0) begin : g_bad_lanes
        $error("int_prod_seq: LANES must divide N");
    end
    if (ACC_W > SAT_W) begin : g_bad_acc
        $error("int_prod_seq: accumulator wider than saturation helper");
    end

    state_t                  state;
    state_t                  state_nx;
    logic [N*W-1:0]          lin_q;
    logic [N*W-1:0]          col_q;
    logic [CW-1:0]           cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] lane_sum;
    logic [SAT_W:0]          sat_r;
    logic                    sat_unused;
    logic                    last;

    // Operands shift left each chunk, so the current chunk is always on top.
    int_prod_lanes #(
        .W     (W),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) u_lanes (
        .a   (lin_q[N*W-1 -: LANES*W]),
        .b   (col_q[N*W-1 -: LANES*W]),
        .sum (lane_sum)
    );

    assign last       = (cnt == KC);
    assign sat_r      = sat_w(SAT_W'(acc), W);
    assign sat_unused = ^sat_r[SAT_W:W+1];

    always_comb begin
        state_nx  = state;
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE) && !rst;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lin_q <= '0;
            col_q <= '0;
            cnt   <= '0;
            acc   <= '0;
            n_out <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        lin_q <= lin;
                        col_q <= col;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    // Final RUN cycle only registers the saturated result.
                    if (last) begin
                        n_out <= sat_r[W:1];
                        ovf   <= sat_r[0];
                    end else begin
                        acc   <= acc + lane_sum;
                        cnt   <= cnt + CW'(1);
                        lin_q <= lin_q << (LANES * W);
                        col_q <= col_q << (LANES * W);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
